// File: rtl/pill_count_ctrl.sv
// pill_count_ctrl: pill sensor conditioning, per-bottle counting, feeder gating and bottle swap control.
// Define PILL_DEBOUNCE_EN to insert a DEBOUNCE_CYCLES stable-sample filter after the synchroniser.
module pill_count_ctrl #(
    parameter int unsigned CNT_W           = 8,
    parameter int unsigned TOT_W           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pause,
    input  logic             pill_in,
    input  logic             bottle_ack,
    input  logic [CNT_W-1:0] target_in,
    input  logic [CNT_W-1:0] bottles_in,
    output logic [CNT_W-1:0] current_count,
    output logic [CNT_W-1:0] target_count,
    output logic [CNT_W-1:0] bottle_count,
    output logic [TOT_W-1:0] total_pills,
    output logic             feeder_en,
    output logic             bottle_req,
    output logic             done,
    output logic             extra_pill,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_PAUSE = 3'd2,
        S_SWAP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             sync1;
    logic             sync2;
    logic             pill_evt;
    logic [CNT_W-1:0] bottle_target;
    logic [CNT_W-1:0] cur_d;
    logic [CNT_W-1:0] tgt_d;
    logic [CNT_W-1:0] bc_d;
    logic [CNT_W-1:0] bt_d;
    logic [TOT_W-1:0] tot_d;
    logic             extra_d;
    logic             start_ok;
    logic [CNT_W-1:0] cur_inc;
    logic [CNT_W-1:0] bc_inc;

`ifdef PILL_DEBOUNCE_EN
    localparam int unsigned DB_W = 8;

    logic            filt;
    logic            filt_d;
    logic [DB_W-1:0] db_cnt;

    // Synchroniser followed by a filter that follows the input only after it has been stable long enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            filt   <= 1'b0;
            filt_d <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync1  <= pill_in;
            sync2  <= sync1;
            filt_d <= filt;
            if (sync2 != filt) begin
                if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    filt   <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign pill_evt = filt & ~filt_d;
`else
    logic       sync3;
    logic [7:0] unused_db;

    assign unused_db = 8'(DEBOUNCE_CYCLES);

    // Two-flop synchroniser plus one delay stage for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= pill_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign pill_evt = sync2 & ~sync3;
`endif

    assign start_ok = start && (target_in != '0) && (bottles_in != '0);
    assign cur_inc  = current_count + CNT_W'(1);
    assign bc_inc   = bottle_count + CNT_W'(1);
    assign state    = state_q;

    // Next-state and next-count logic.
    always_comb begin
        state_d = state_q;
        cur_d   = current_count;
        tgt_d   = target_count;
        bc_d    = bottle_count;
        bt_d    = bottle_target;
        tot_d   = total_pills;
        extra_d = extra_pill;
        case (state_q)
            S_IDLE, S_DONE: begin
                if ((state_q == S_DONE) && pill_evt) begin
                    extra_d = 1'b1;
                end
                if (start_ok) begin
                    tgt_d   = target_in;
                    bt_d    = bottles_in;
                    cur_d   = '0;
                    bc_d    = '0;
                    tot_d   = '0;
                    extra_d = 1'b0;
                    state_d = S_FILL;
                end
            end
            S_FILL, S_PAUSE: begin
                if (pill_evt) begin
                    cur_d = cur_inc;
                    if (total_pills != '1) begin
                        tot_d = total_pills + TOT_W'(1);
                    end
                end
                // A terminal pill wins over the pause level.
                if (pill_evt && (cur_inc == target_count)) begin
                    state_d = S_SWAP;
                end else if (pause) begin
                    state_d = S_PAUSE;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_SWAP: begin
                if (pill_evt) begin
                    extra_d = 1'b1;
                end
                if (bottle_ack) begin
                    bc_d = bc_inc;
                    if (bc_inc == bottle_target) begin
                        state_d = S_DONE;
                    end else begin
                        cur_d   = '0;
                        state_d = S_FILL;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and registered state-decoded outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            current_count <= '0;
            target_count  <= '0;
            bottle_count  <= '0;
            bottle_target <= '0;
            total_pills   <= '0;
            extra_pill    <= 1'b0;
            feeder_en     <= 1'b0;
            bottle_req    <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_q       <= state_d;
            current_count <= cur_d;
            target_count  <= tgt_d;
            bottle_count  <= bc_d;
            bottle_target <= bt_d;
            total_pills   <= tot_d;
            extra_pill    <= extra_d;
            feeder_en     <= (state_d == S_FILL);
            bottle_req    <= (state_d == S_SWAP);
            done          <= (state_d == S_DONE);
        end
    end

endmodule
